// File: rtl/delay_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : delay_ctrl_pkg
// Description : Shared types and constants for the SRAM delay-line controller.
//               Defines the sequencer state encoding, the sample width, the
//               feedback saturation limits and the Q0.8 gain shift.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package delay_ctrl_pkg;

    // Sequencer states; one sample walks IDLE -> RD -> CAP -> WR -> OUT.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam int c_SAMPLE_W = 16;

    // Clamp values for the feedback write word (signed 16-bit extremes).
    localparam logic signed [c_SAMPLE_W-1:0] c_SAT_MAX = 16'sh7FFF;
    localparam logic signed [c_SAMPLE_W-1:0] c_SAT_MIN = 16'sh8000;

    // fb_gain is unsigned Q0.8, so the product is rescaled by 8 bits.
    localparam int c_FB_SHIFT = 8;

endpackage : delay_ctrl_pkg
`default_nettype wire

// File: rtl/delay_fb_sat.sv
`default_nettype none
// ============================================================================
// Module      : delay_fb_sat
// Description : Feedback mixer for the echo write path:
//               wdata = sat(in_sample + ((wet * gain) >>> 8)).
//               Only instantiated when DELAY_CTRL_FEEDBACK_EN is defined.
// Ports       : in_sample [DATA_WIDTH] - dry input sample (signed)
//               wet       [DATA_WIDTH] - delayed sample (signed)
//               gain      [8]          - unsigned Q0.8 feedback gain
//               wdata     [DATA_WIDTH] - saturated word written to the SRAM
// Revision    : 1.0 - initial release
// ============================================================================
module delay_fb_sat
    import delay_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = c_SAMPLE_W
) (
    input  logic [DATA_WIDTH-1:0] in_sample,
    input  logic [DATA_WIDTH-1:0] wet,
    input  logic [7:0]            gain,
    output logic [DATA_WIDTH-1:0] wdata
);

    localparam int c_PROD_W = DATA_WIDTH + 9;   // signed wet x 9-bit signed gain
    localparam int c_SUM_W  = DATA_WIDTH + 10;  // one guard bit for the add

    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_PROD_W-1:0] w_scaled;
    logic signed [c_SUM_W-1:0]  w_sum;

    // Gain is zero-extended into a positive signed operand so the multiply
    // stays signed and the sign of wet carries through.
    assign w_prod   = c_PROD_W'($signed(wet)) * c_PROD_W'($signed({1'b0, gain}));
    assign w_scaled = w_prod >>> c_FB_SHIFT;
    assign w_sum    = c_SUM_W'($signed(in_sample)) + c_SUM_W'(w_scaled);

    always_comb begin
        wdata = w_sum[DATA_WIDTH-1:0];
        if (w_sum > c_SUM_W'(c_SAT_MAX)) begin
            wdata = DATA_WIDTH'(c_SAT_MAX);
        end else if (w_sum < c_SUM_W'(c_SAT_MIN)) begin
            wdata = DATA_WIDTH'(c_SAT_MIN);
        end
    end

endmodule : delay_fb_sat
`default_nettype wire

// File: rtl/sram_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_delay_ctrl
// Description : Runs a dual-port sample SRAM as a circular audio delay line.
//               Each accepted sample reads the delayed sample on port 1, then
//               writes the new sample on port 0, then offers the delayed (wet)
//               sample on a valid/ready output.
//               Optional macro DELAY_CTRL_FEEDBACK_EN adds fb_gain and mixes
//               scaled wet back into the written word (saturated).
// Ports       : clk, rst_n (async, active low)
//               in_valid/in_ready/in_data/delay_len - input sample stream
//               out_valid/out_ready/out_data        - delayed sample stream
//               sram_csb0/web0/addr0/din0           - SRAM port 0 (write only)
//               sram_csb1/addr1/dout1               - SRAM port 1 (read only)
//               fb_gain [8] (DELAY_CTRL_FEEDBACK_EN only) - Q0.8 gain
// Revision    : 1.0 - initial release
// ============================================================================
module sram_delay_ctrl
    import delay_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] delay_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
`ifdef DELAY_CTRL_FEEDBACK_EN
    ,
    input  logic [7:0]            fb_gain
`endif
);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_fill_cnt;   // samples written so far, saturating
    logic [DATA_WIDTH-1:0] r_in_sample;
    logic [ADDR_WIDTH-1:0] r_dly;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_rd_en;      // port-1 read is issued for this sample
    logic [DATA_WIDTH-1:0] r_wet;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_accept;
    logic                  w_out_fire;

    assign w_accept   = (r_state == IDLE) && in_valid;
    assign w_out_fire = (r_state == OUT) && out_ready;
    assign out_data   = r_wet;

`ifdef DELAY_CTRL_FEEDBACK_EN
    logic [7:0] r_fb_gain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fb_gain <= '0;
        end else if (w_accept) begin
            r_fb_gain <= fb_gain;
        end
    end

    delay_fb_sat #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fb_sat (
        .in_sample  (r_in_sample),
        .wet        (r_wet),
        .gain       (r_fb_gain),
        .wdata      (w_wdata)
    );
`else
    assign w_wdata = r_in_sample;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and SRAM/handshake strobes. Every strobe is a pure function
    // of the current state, so each SRAM access lasts exactly one cycle.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        sram_csb0    = 1'b1;
        sram_web0    = 1'b1;
        sram_addr0   = '0;
        sram_din0    = '0;
        sram_csb1    = 1'b1;
        sram_addr1   = '0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = RD;
                end
            end
            RD: begin
                // The state is still visited when the read is skipped so the
                // accept-to-output latency never varies.
                sram_csb1    = ~r_rd_en;
                sram_addr1   = r_rd_en ? r_rd_addr : '0;
                w_next_state = CAP;
            end
            CAP: begin
                w_next_state = WR;
            end
            WR: begin
                sram_csb0    = 1'b0;
                sram_web0    = 1'b0;
                sram_addr0   = r_wr_ptr;
                sram_din0    = w_wdata;
                w_next_state = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_in_sample <= '0;
            r_dly       <= '0;
            r_rd_addr   <= '0;
            r_rd_en     <= 1'b0;
            r_wet       <= '0;
        end else begin
            if (w_accept) begin
                r_in_sample <= in_data;
                r_dly       <= delay_len;
                // Modular subtraction gives the circular read address.
                r_rd_addr   <= r_wr_ptr - delay_len;
                // No read until the line holds at least dly samples.
                r_rd_en     <= (delay_len != '0) && (r_fill_cnt >= delay_len);
            end
            // Port-1 data arrives one cycle after RD, i.e. during CAP.
            if (r_state == CAP) begin
                if (r_rd_en) begin
                    r_wet <= sram_dout1;
                end else if (r_dly == '0) begin
                    r_wet <= r_in_sample;
                end else begin
                    r_wet <= '0;
                end
            end
            if (w_out_fire) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
                if (r_fill_cnt != '1) begin
                    r_fill_cnt <= r_fill_cnt + ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule : sram_delay_ctrl
`default_nettype wire

// File: tb/tb_sram_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_delay_ctrl
// Description : Directed self-checking bench for sram_delay_ctrl with a
//               behavioural dual-port SRAM (inputs registered on posedge,
//               access on negedge, 1-cycle read latency).
// Ports       : none (testbench top)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_delay_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [13:0] delay_len;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        sram_csb0;
    logic        sram_web0;
    logic [13:0] sram_addr0;
    logic [15:0] sram_din0;
    logic        sram_csb1;
    logic [13:0] sram_addr1;
    logic [15:0] sram_dout1;
`ifdef DELAY_CTRL_FEEDBACK_EN
    logic [7:0]  fb_gain;
`endif

    int          errors;
    int          checks;
    logic [13:0] exp_ptr;

    sram_delay_ctrl #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (14)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .delay_len  (delay_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1)
`ifdef DELAY_CTRL_FEEDBACK_EN
        ,
        .fb_gain    (fb_gain)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM
    bit   [15:0] mem [0:16383];
    logic        q_csb0, q_web0, q_csb1;
    logic [13:0] q_addr0, q_addr1;
    logic [15:0] q_din0;

    initial sram_dout1 = '0;

    always @(posedge clk) begin
        q_csb0  <= sram_csb0;
        q_web0  <= sram_web0;
        q_addr0 <= sram_addr0;
        q_din0  <= sram_din0;
        q_csb1  <= sram_csb1;
        q_addr1 <= sram_addr1;
    end

    always @(negedge clk) begin
        if (q_csb0 === 1'b0 && q_web0 === 1'b0) mem[q_addr0] <= q_din0;
        if (q_csb1 === 1'b0) sram_dout1 <= mem[q_addr1];
    end

    // Access monitor
    logic [13:0] last_wr_addr;
    logic [15:0] last_wr_data;
    logic [13:0] last_rd_addr;
    int          rd_count;

    initial begin
        last_wr_addr = '0;
        last_wr_data = '0;
        last_rd_addr = '0;
        rd_count     = 0;
    end

    always @(posedge clk) begin
        if (sram_csb0 === 1'b0 && sram_web0 === 1'b0) begin
            last_wr_addr <= sram_addr0;
            last_wr_data <= sram_din0;
        end
        if (sram_csb1 === 1'b0) begin
            last_rd_addr <= sram_addr1;
            rd_count     <= rd_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction. Inputs are scrambled right after the accept edge
    // to show that only the values present at accept are used.
    task automatic send(input string tag, input logic [15:0] d, input logic [13:0] dl,
                        input int stall, input logic [15:0] exp_out, input logic [15:0] exp_wd);
        int          n;
        int          lat;
        logic [15:0] held;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdy"}, in_ready, 1);
        in_valid  = 1'b1;
        in_data   = d;
        delay_len = dl;
        out_ready = (stall == 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = 16'hDEAD;
        delay_len = 14'h2AAA;
        lat = 1;
        while (!out_valid && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 4);
        check({tag, "_data"}, out_data, exp_out);
        check({tag, "_wraddr"}, last_wr_addr, exp_ptr);
        check({tag, "_wrdata"}, last_wr_data, exp_wd);
        held = out_data;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold"}, out_data, held);
            check({tag, "_quiet"}, {in_ready, sram_csb0, sram_csb1, out_valid}, 4'b0111);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_ptr = exp_ptr + 14'd1;
    endtask

    initial begin
        int rc;
        errors    = 0;
        checks    = 0;
        exp_ptr   = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        delay_len = '0;
        out_ready = 1'b1;
`ifdef DELAY_CTRL_FEEDBACK_EN
        fb_gain   = 8'h00;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset / idle state
        check("rst_in_ready",  in_ready,   1);
        check("rst_out_valid", out_valid,  0);
        check("rst_out_data",  out_data,   0);
        check("rst_csb0",      sram_csb0,  1);
        check("rst_web0",      sram_web0,  1);
        check("rst_csb1",      sram_csb1,  1);
        check("rst_addr0",     sram_addr0, 0);
        check("rst_addr1",     sram_addr1, 0);
        check("rst_din0",      sram_din0,  0);

        // Delay of 4: first four outputs come from an unfilled line
        for (int k = 1; k <= 10; k++) begin
            send("dly4", 16'(k), 14'd4, 0, (k <= 4) ? 16'd0 : 16'(k - 4), 16'(k));
        end
        check("dly4_reads", rd_count, 6);

        // Bypass: zero delay returns the input, no port-1 read
        rc = rd_count;
        send("bypass", 16'h1234, 14'd0, 0, 16'h1234, 16'h1234);
        check("bypass_noread", rd_count, rc);

        // Back-pressure: addr 11-4=7 holds sample 8
        send("stall", 16'h0055, 14'd4, 10, 16'd8, 16'h0055);
        send("after_stall", 16'h0099, 14'd0, 0, 16'h0099, 16'h0099);

        // Pointer wrap
        @(negedge clk);
        force u_dut.r_wr_ptr = 14'h3FFF;
        @(posedge clk);
        #1;
        release u_dut.r_wr_ptr;
        exp_ptr = 14'h3FFF;
        send("wrapA", 16'hAAAA, 14'd1, 0, 16'h0000, 16'hAAAA);
        check("wrapA_rdaddr", last_rd_addr, 14'h3FFE);
        send("wrapB", 16'hBBBB, 14'd1, 0, 16'hAAAA, 16'hBBBB);
        check("wrapB_rdaddr", last_rd_addr, 14'h3FFF);

        // Reset while in WR
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 16'h4444;
        delay_len = 14'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("midrst_in_wr", sram_csb0, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {in_ready, out_valid, sram_csb0, sram_web0, sram_csb1}, 5'b10111);
        check("midrst_out_data", out_data, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ptr = '0;
        send("post_rst", 16'h0077, 14'd0, 0, 16'h0077, 16'h0077);
        // fill_cnt is 1 < 2, so no read of the stale 0xAAAA at 0x3FFF
        send("post_rst_fill", 16'h0088, 14'd2, 0, 16'h0000, 16'h0088);

`ifdef DELAY_CTRL_FEEDBACK_EN
        // 0x7000 + (0x7000*0x80)>>8 = 0xA800 -> clamps to 0x7FFF
        fb_gain = 8'h80;
        send("fb_satpos", 16'h7000, 14'd0, 0, 16'h7000, 16'h7FFF);
        // 0x8000 + (-0x8000*0x80)>>8 = -0xC000 -> clamps to 0x8000
        send("fb_satneg", 16'h8000, 14'd0, 0, 16'h8000, 16'h8000);
        // -0x1000 + (-0x1000*0x40)>>8 = -0x1400 = 0xEC00, no clamp
        fb_gain = 8'h40;
        send("fb_lin", 16'hF000, 14'd0, 0, 16'hF000, 16'hEC00);
        fb_gain = 8'h00;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sram_delay_ctrl
`default_nettype wire
